// File: rtl/operand_entry_pkg.sv
// Purpose: shared types and defaults for the operand entry block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: state_t (FSM state encoding shown on LEDs/HEX) and the default
// debounce length (20 ms at the 50 MHz board clock).
package operand_entry_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

    // 2'd3 is not a legal state; the FSM steers it back to ST_ENTER_A.
    typedef enum logic [1:0] {
        ST_ENTER_A = 2'd0,
        ST_ENTER_B = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/operand_entry_key_debounce.sv
// Purpose: synchronise and debounce one active-low pushbutton; emit a one-cycle press pulse.
// Latency: press pulse is visible DEBOUNCE_CYCLES+2 cycles after a clean key-down edge.
// Backpressure: none; the key is sampled every cycle and the pulse is never held.
//
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   key_n      : raw pushbutton level, active-low, asynchronous and bouncy
//   press      : registered one-cycle pulse when the debounced level falls 1 -> 0
module key_debounce
    import operand_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter counts disagreeing cycles already seen; the cycle in which
    // it reads DEBOUNCE_CYCLES-1 is the last one needed to accept the change.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_lvl;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_lvl  <= 1'b1;
            level     <= 1'b1;
            cnt       <= '0;
            press     <= 1'b0;
        end else begin
            sync_meta <= key_n;
            sync_lvl  <= sync_meta;
            press     <= 1'b0;
            if (sync_lvl == level) begin
                // Any agreeing cycle restarts the stability window.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_lvl;
                // Only the falling (pressed) transition produces an event.
                press <= ~sync_lvl;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_entry.sv
// Purpose: capture two operands from slide switches on debounced ENTER presses, CLEAR resets them.
// Latency: a/b/load_pulse update one cycle after the debounced press pulse.
// Backpressure: none; the downstream adder is combinational and always accepts.
//
// Ports:
//   clk, reset   : 50 MHz clock, asynchronous active-high reset
//   sw           : raw slide switches, sampled directly at capture time
//   key_enter_n  : raw ENTER pushbutton (active-low)
//   key_clear_n  : raw CLEAR pushbutton (active-low)
//   a, b         : registered operands for the adder
//   ab_valid     : high while both operands are held (DONE)
//   state        : FSM state encoding for the display
//   load_pulse   : one-cycle pulse coincident with a capture into a or b
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned WIDTH           = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             key_enter_n,
    input  logic             key_clear_n,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             ab_valid,
    output logic [1:0]       state,
    output logic             load_pulse
);

    logic   enter_press;
    logic   clear_press;
    state_t state_q;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_deb (
        .clk   (clk),
        .reset (reset),
        .key_n (key_enter_n),
        .press (enter_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_deb (
        .clk   (clk),
        .reset (reset),
        .key_n (key_clear_n),
        .press (clear_press)
    );

    // sw is deliberately not synchronised: switches are static while a key
    // is being pressed, so a metastable capture is not a practical concern.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_ENTER_A;
            a          <= '0;
            b          <= '0;
            ab_valid   <= 1'b0;
            load_pulse <= 1'b0;
        end else begin
            load_pulse <= 1'b0;
            ab_valid   <= 1'b0;
            if (clear_press) begin
                // Clear has priority over a simultaneous enter and is not a load.
                a       <= '0;
                b       <= '0;
                state_q <= ST_ENTER_A;
            end else begin
                case (state_q)
                    ST_ENTER_A: begin
                        if (enter_press) begin
                            a          <= sw;
                            state_q    <= ST_ENTER_B;
                            load_pulse <= 1'b1;
                        end
                    end
                    ST_ENTER_B: begin
                        if (enter_press) begin
                            b          <= sw;
                            state_q    <= ST_DONE;
                            load_pulse <= 1'b1;
                            ab_valid   <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (enter_press) begin
                            // Start a new calculation: a is the new first operand.
                            a          <= sw;
                            b          <= '0;
                            state_q    <= ST_ENTER_B;
                            load_pulse <= 1'b1;
                        end else begin
                            ab_valid <= 1'b1;
                        end
                    end
                    default: state_q <= ST_ENTER_A;
                endcase
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Purpose: self-checking bench for operand_entry with DEBOUNCE_CYCLES=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_operand_entry;

    localparam int DEB = 4;
    localparam int W   = 3;

    logic         clk;
    logic         reset;
    logic [W-1:0] sw;
    logic         key_enter_n;
    logic         key_clear_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ab_valid;
    logic [1:0]   state;
    logic         load_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    operand_entry #(.DEBOUNCE_CYCLES(DEB), .WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .key_enter_n (key_enter_n),
        .key_clear_n (key_clear_n),
        .a           (a),
        .b           (b),
        .ab_valid    (ab_valid),
        .state       (state),
        .load_pulse  (load_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each key: raw level reaches the filter two edges late; the filter keeps
    // the length of the current run of samples that disagree with the accepted
    // level and accepts the new level once that run reaches DEB.
    logic       m_hist0 [2];
    logic       m_hist1 [2];
    logic       m_lvl   [2];
    int         m_run   [2];
    bit         m_press [2];
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic [1:0]   m_state;
    bit           m_lp;
    bit           m_valid;

    task automatic model_key(input int k, input logic raw);
        logic seen;
        seen       = m_hist1[k];
        m_hist1[k] = m_hist0[k];
        m_hist0[k] = raw;
        m_press[k] = 1'b0;
        if (seen == m_lvl[k]) begin
            m_run[k] = 0;
        end else begin
            m_run[k] = m_run[k] + 1;
            if (m_run[k] == DEB) begin
                m_lvl[k]   = seen;
                m_run[k]   = 0;
                m_press[k] = (seen == 1'b0);
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_hist0[k] = 1'b1;
                m_hist1[k] = 1'b1;
                m_lvl[k]   = 1'b1;
                m_run[k]   = 0;
                m_press[k] = 1'b0;
            end
            m_a = '0; m_b = '0; m_state = 2'd0; m_lp = 1'b0; m_valid = 1'b0;
        end else begin
            // The operand logic reacts to the press events from the previous edge.
            m_lp = 1'b0;
            if (m_press[1]) begin
                m_a = '0; m_b = '0; m_state = 2'd0;
            end else if (m_press[0]) begin
                m_lp = 1'b1;
                if (m_state == 2'd0) begin
                    m_a = sw; m_state = 2'd1;
                end else if (m_state == 2'd1) begin
                    m_b = sw; m_state = 2'd2;
                end else begin
                    m_a = sw; m_b = '0; m_state = 2'd1;
                end
            end
            m_valid = (m_state == 2'd2);
            model_key(0, key_enter_n);
            model_key(1, key_clear_n);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_keys(input int n);
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        repeat (n) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({a, b, ab_valid, state, load_pulse} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: a=%0d b=%0d valid=%0b state=%0d lp=%0b, required all 0",
                     a, b, ab_valid, state, load_pulse);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({a, b, ab_valid, state, load_pulse} !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: a=%0d b=%0d valid=%0b state=%0d lp=%0b, required all 0",
                     a, b, ab_valid, state, load_pulse);
        end
    endtask

    task automatic test_first_press();
        int lp_cnt = 0;
        sw = 3'd5;
        key_enter_n = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_checks++;
            if (load_pulse !== (i == 7)) begin
                n_fail++;
                $display("FAIL first_press_lp cycle %0d: got %0b, required %0b", i, load_pulse, (i == 7));
            end
        end
        n_checks++;
        if (a !== 3'd5 || b !== 3'd0 || state !== 2'd1 || ab_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_press_regs: a=%0d b=%0d state=%0d valid=%0b, required 5 0 1 0",
                     a, b, state, ab_valid);
        end
        key_enter_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (load_pulse) lp_cnt++;
        end
        n_checks++;
        if (lp_cnt != 0) begin
            n_fail++;
            $display("FAIL release_no_event: %0d pulses, required 0", lp_cnt);
        end
    endtask

    task automatic test_second_press();
        logic [3:0] sum;
        sw = 3'd6;
        key_enter_n = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_checks++;
            if (load_pulse !== (i == 7)) begin
                n_fail++;
                $display("FAIL second_press_lp cycle %0d: got %0b, required %0b", i, load_pulse, (i == 7));
            end
        end
        sum = {1'b0, a} + {1'b0, b};
        n_checks++;
        if (a !== 3'd5 || b !== 3'd6 || state !== 2'd2 || ab_valid !== 1'b1 || sum !== 4'd11) begin
            n_fail++;
            $display("FAIL second_press_regs: a=%0d b=%0d state=%0d valid=%0b sum=%0d, required 5 6 2 1 11",
                     a, b, state, ab_valid, sum);
        end
        release_keys(10);
    endtask

    task automatic test_bounce();
        int lp_cnt = 0;
        int lp_at  = -1;
        sw = 3'd2;
        for (int c = 0; c < 20; c++) begin
            key_enter_n = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            if (load_pulse) lp_cnt++;
        end
        key_enter_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (load_pulse) begin
                lp_cnt++;
                lp_at = i;
            end
            n_checks++;
            if (load_pulse !== m_lp || a !== m_a || b !== m_b || state !== m_state) begin
                n_fail++;
                $display("FAIL bounce_model cycle %0d: lp=%0b a=%0d b=%0d st=%0d, required lp=%0b a=%0d b=%0d st=%0d",
                         i, load_pulse, a, b, state, m_lp, m_a, m_b, m_state);
            end
        end
        n_checks++;
        if (lp_cnt != 1 || lp_at != 7) begin
            n_fail++;
            $display("FAIL bounce_single_capture: %0d pulses at cycle %0d, required 1 at 7", lp_cnt, lp_at);
        end
        n_checks++;
        if (a !== 3'd2 || b !== 3'd0 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL bounce_regs: a=%0d b=%0d state=%0d, required 2 0 1", a, b, state);
        end
        release_keys(10);
    endtask

    task automatic test_clear_and_enter();
        int lp_cnt = 0;
        sw = 3'd4;
        key_enter_n = 1'b0;
        repeat (9) tick();
        release_keys(10);
        n_checks++;
        if (state !== 2'd2 || b !== 3'd4) begin
            n_fail++;
            $display("FAIL clear_setup_done: state=%0d b=%0d, required 2 4", state, b);
        end
        sw = 3'd7;
        key_enter_n = 1'b0;
        key_clear_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (load_pulse) lp_cnt++;
            n_checks++;
            if (a !== m_a || b !== m_b || state !== m_state || ab_valid !== m_valid) begin
                n_fail++;
                $display("FAIL clear_model cycle %0d: a=%0d b=%0d st=%0d v=%0b, required a=%0d b=%0d st=%0d v=%0b",
                         i, a, b, state, ab_valid, m_a, m_b, m_state, m_valid);
            end
        end
        n_checks++;
        if (lp_cnt != 0 || a !== 3'd0 || b !== 3'd0 || state !== 2'd0 || ab_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_wins: pulses=%0d a=%0d b=%0d state=%0d valid=%0b, required 0 0 0 0 0",
                     lp_cnt, a, b, state, ab_valid);
        end
        release_keys(10);
    endtask

    task automatic test_reset_mid_debounce();
        sw = 3'd7;
        key_enter_n = 1'b0;
        repeat (9) tick();
        release_keys(10);
        sw = 3'd3;
        key_enter_n = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({a, b, ab_valid, state, load_pulse} !== '0) begin
            n_fail++;
            $display("FAIL reset_abort: a=%0d b=%0d valid=%0b state=%0d lp=%0b, required all 0",
                     a, b, ab_valid, state, load_pulse);
        end
        reset = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_checks++;
            if (load_pulse !== (i == 7) || a !== ((i >= 7) ? 3'd3 : 3'd0)) begin
                n_fail++;
                $display("FAIL held_after_reset cycle %0d: lp=%0b a=%0d, required lp=%0b a=%0d",
                         i, load_pulse, a, (i == 7), (i >= 7) ? 3 : 0);
            end
        end
        release_keys(10);
    endtask

    task automatic test_long_hold();
        int lp_cnt = 0;
        key_clear_n = 1'b0;
        repeat (9) tick();
        release_keys(10);
        sw = 3'd1;
        key_enter_n = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (load_pulse) lp_cnt++;
        end
        n_checks++;
        if (lp_cnt != 1 || state !== 2'd1 || a !== 3'd1) begin
            n_fail++;
            $display("FAIL long_hold: pulses=%0d state=%0d a=%0d, required 1 1 1", lp_cnt, state, a);
        end
        release_keys(10);
    endtask

    task automatic test_random();
        for (int s = 0; s < 60; s++) begin
            int len;
            sw          = W'($urandom_range(0, 7));
            key_enter_n = 1'($urandom_range(0, 1));
            key_clear_n = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            len         = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                tick();
                n_checks++;
                if (a !== m_a || b !== m_b || state !== m_state ||
                    ab_valid !== m_valid || load_pulse !== m_lp) begin
                    n_fail++;
                    $display("FAIL random seg %0d: a=%0d b=%0d st=%0d v=%0b lp=%0b, required a=%0d b=%0d st=%0d v=%0b lp=%0b",
                             s, a, b, state, ab_valid, load_pulse, m_a, m_b, m_state, m_valid, m_lp);
                end
            end
        end
        release_keys(10);
    endtask

    initial begin
        reset       = 1'b1;
        sw          = '0;
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        test_reset();
        test_first_press();
        test_second_press();
        test_bounce();
        test_clear_and_enter();
        test_reset_mid_debounce();
        test_long_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
